// File: rtl/access_trace_pkg.sv
// Shared types for the access-stage trace recorder: record layout, trigger modes, FSM states.
package access_trace_pkg;

    localparam int TRACE_ADDR_W = 64;
    localparam int TRACE_DATA_W = 64;

    typedef struct packed {
        logic [TRACE_ADDR_W-1:0] pc;
        logic [4:0]              rd;
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] data;
        logic [TRACE_DATA_W-1:0] d_data;
    } trace_rec_t;

    typedef enum logic [1:0] {
        TRIG_FREE = 2'b00,
        TRIG_PC   = 2'b01,
        TRIG_ADDR = 2'b10,
        TRIG_RD   = 2'b11
    } trig_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } trace_state_e;

endpackage

// File: rtl/access_trace_buf_if.sv
// Access-stage bus as seen by the trace recorder; the monitor only ever uses the slave side.
interface access_trace_buf_if;
    import access_trace_pkg::*;

    logic                    stall;
    logic [TRACE_ADDR_W-1:0] pc;
    logic [4:0]              rd;
    logic [TRACE_ADDR_W-1:0] addr;
    logic [TRACE_DATA_W-1:0] data;
    logic                    request;
    logic                    d_valid;
    logic [TRACE_DATA_W-1:0] d_data;

    modport master (output stall, pc, rd, addr, data, request, d_valid, d_data);
    modport slave  (input  stall, pc, rd, addr, data, request, d_valid, d_data);
endinterface

// File: rtl/access_trace_buf_ram.sv
// Trace storage: one write port, one registered read port, read-before-write on address collision.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             q
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) q <= mem[raddr];
    end

endmodule

// File: rtl/access_trace_buf.sv
// Access-stage trace recorder: circular capture with PC/addr/rd trigger, post-trigger depth, freeze.
// Optional ACCESS_TRACE_DISPLAY_EN prints every stored record (simulation only).
module access_trace_buf
    import access_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = TRACE_ADDR_W,
    parameter int DATA_W = TRACE_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    access_trace_buf_if.slave        bus,
    input  logic                     arm,
    input  logic [1:0]               trig_mode,
    input  logic [ADDR_W-1:0]        trig_val,
    input  logic [$clog2(DEPTH):0]   post_cnt,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic                     rd_valid,
    output trace_rec_t               rd_rec,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state,
    output logic                     triggered
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    trace_state_e  state_reg, state_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] post_reg, post_next;
    logic          trig_reg, trig_next;
    logic          rd_valid_reg, rd_zero_reg;

    logic          ev, match, we;
    logic [AW-1:0] waddr, raddr;
    logic [CW-1:0] phys_full;
    trace_rec_t    wdata, ram_q;
    trig_mode_e    mode;

    assign ev   = bus.request & bus.d_valid & ~bus.stall;
    assign mode = trig_mode_e'(trig_mode);

    always_comb begin
        case (mode)
            TRIG_PC:   match = (bus.pc == trig_val);
            TRIG_ADDR: match = (bus.addr == trig_val);
            TRIG_RD:   match = (bus.rd == trig_val[4:0]);
            default:   match = 1'b0;
        endcase
    end

    assign wdata = '{pc: bus.pc, rd: bus.rd, addr: bus.addr, data: bus.data, d_data: bus.d_data};

    // arm overrides every state; a coincident ev lands in slot 0 of the fresh buffer
    always_comb begin
        state_next  = state_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        post_next   = post_reg;
        trig_next   = trig_reg;
        we          = 1'b0;
        waddr       = wr_ptr_reg;
        if (arm) begin
            state_next  = ARMED;
            trig_next   = 1'b0;
            post_next   = '0;
            waddr       = '0;
            we          = ev;
            wr_ptr_next = ev ? AW'(1) : '0;
            count_next  = ev ? CW'(1) : '0;
        end else if ((state_reg == ARMED || state_reg == POST) && ev) begin
            we          = 1'b1;
            wr_ptr_next = wr_ptr_reg + AW'(1);
            if (count_reg != CW'(DEPTH)) count_next = count_reg + CW'(1);
            if (state_reg == ARMED) begin
                if (match) begin
                    trig_next = 1'b1;
                    if (post_cnt == '0) begin
                        state_next = DONE;
                    end else begin
                        post_next  = post_cnt;
                        state_next = POST;
                    end
                end
            end else begin
                post_next = post_reg - CW'(1);
                if (post_reg == CW'(1)) state_next = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            post_reg     <= '0;
            trig_reg     <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_zero_reg  <= 1'b1;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            post_reg     <= post_next;
            trig_reg     <= trig_next;
            rd_valid_reg <= rd_en;
            rd_zero_reg  <= ({1'b0, rd_idx} >= count_reg);
        end
    end

    // rd_idx counts from the oldest entry; with a full buffer that is the slot at wr_ptr
    assign phys_full = {1'b0, wr_ptr_reg} - count_reg + {1'b0, rd_idx};
    assign raddr     = phys_full[AW-1:0];

    trace_ram #(
        .DEPTH (DEPTH),
        .W     ($bits(trace_rec_t))
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (rd_en),
        .raddr (raddr),
        .q     (ram_q)
    );

    assign rd_valid  = rd_valid_reg;
    assign rd_rec    = (rd_valid_reg && !rd_zero_reg) ? ram_q : '0;
    assign count     = count_reg;
    assign state     = state_reg;
    assign triggered = trig_reg;

`ifdef ACCESS_TRACE_DISPLAY_EN
    string abi_names [32] = '{
        "zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
        "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
        "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
        "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"};

    function automatic bit check_verbose(input logic [ADDR_W-1:0] p);
        return p != '1;
    endfunction

    always @(posedge clk) begin
        if (rst_n && we && check_verbose(bus.pc))
            $display("%0t pc=%h %s addr=%h data=%h d_data=%h state=%s%s",
                     $time, bus.pc, abi_names[bus.rd], bus.addr, bus.data, bus.d_data,
                     state_reg.name(),
                     (!arm && state_reg == ARMED && match) ? " TRIG" : "");
    end
`endif

endmodule
